avalon_mem_slave: RTL and testbench

- Synthesizable Avalon-MM memory responder: the slave end of the CPU's Avalon bus master (mips_cpu_bus).
- Replaces the bench's behavioural always_comb RAM model with cycle-accurate timing, waitrequest stalls, byte-enabled writes and two address windows (data at 0x00000000, instructions at the reset vector 0xBFC00000).
- Provides a debug read port so benches can check memory contents without using the bus.

---
 rtl/avalon_mem_pkg.sv | 21 ++
 rtl/avalon_mem_decode.sv | 35 +++
 rtl/avalon_mem_slave.sv | 135 +++++++++++++
 tb/tb_avalon_mem_slave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the Avalon-MM memory responder and its address decoder.
package avalon_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_DATA_BASE  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_INSTR_BASE = 32'hBFC0_0000;

   // Fibonacci LFSR, taps 8,6,5,4 expressed as a mask over bits [7:0].
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] value);
      return {value[6:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/avalon_mem_decode.sv
// Maps a byte address onto the data or instruction window; flags misses and misaligned addresses.
module avalon_mem_decode
   import avalon_mem_pkg::*;
#(
   parameter int          WINDOW_WORDS = 1024,
   parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE,
   parameter logic [31:0] INSTR_BASE   = DEFAULT_INSTR_BASE,
   localparam int         OFF_W        = $clog2(WINDOW_WORDS)
) (
   input  logic [31:0]      address,
   output logic             hit,
   output logic             window_sel,
   output logic [OFF_W-1:0] offset,
   output logic             fault
);

   localparam logic [31:0] SPAN = 32'(WINDOW_WORDS) << 2;

   logic [31:0] data_off;
   logic [31:0] instr_off;
   logic        in_data;
   logic        in_instr;

   // The lower-bound test keeps an address below a base from wrapping into its window.
   assign data_off   = address - DATA_BASE;
   assign instr_off  = address - INSTR_BASE;
   assign in_data    = (address >= DATA_BASE) && (data_off < SPAN);
   assign in_instr   = (address >= INSTR_BASE) && (instr_off < SPAN);

   assign hit        = in_data || in_instr;
   assign window_sel = in_instr && !in_data;
   assign offset     = window_sel ? instr_off[OFF_W+1:2] : data_off[OFF_W+1:2];
   assign fault      = !hit || (address[1:0] != 2'b00);

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory responder with waitrequest stalls, byte-enabled writes and a debug read port.
module avalon_mem_slave
   import avalon_mem_pkg::*;
#(
   parameter int          WINDOW_WORDS = 1024,
   parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE,
   parameter logic [31:0] INSTR_BASE   = DEFAULT_INSTR_BASE,
   parameter int          WAIT_STATES  = 1,
   parameter bit          RANDOM_WAIT  = 1'b0,
   parameter              INIT_FILE    = "",
   localparam int         OFF_W        = $clog2(WINDOW_WORDS),
   localparam int         IDX_W        = OFF_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      address,
   input  logic             read,
   input  logic             write,
   input  logic [3:0]       byteenable,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             waitrequest,
   output logic             bus_error,
   input  logic [IDX_W-1:0] dbg_index,
   output logic [31:0]      dbg_rdata
);

   logic [31:0] mem [2*WINDOW_WORDS];

   initial begin
      for (int i = 0; i < 2*WINDOW_WORDS; i++)
         mem[i] = 32'd0;
   end

   state_t           state_reg, state_next;
   logic [7:0]       cnt_reg, cnt_next;
   logic [7:0]       lfsr_reg;
   logic [7:0]       n_wait;
   logic             hit, window_sel, addr_fault, fault, req;
   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] idx;
   logic             do_write;

   avalon_mem_decode #(
      .WINDOW_WORDS (WINDOW_WORDS),
      .DATA_BASE    (DATA_BASE),
      .INSTR_BASE   (INSTR_BASE)
   ) u_decode (
      .address    (address),
      .hit        (hit),
      .window_sel (window_sel),
      .offset     (offset),
      .fault      (addr_fault)
   );

   assign req    = read | write;
   assign fault  = addr_fault || !hit || (read && write);
   assign idx    = {window_sel, offset};
   assign n_wait = 8'(WAIT_STATES) + (RANDOM_WAIT ? {6'd0, lfsr_reg[1:0]} : 8'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req) begin
               if (n_wait == 8'd1) begin
                  state_next = ACK;
               end else begin
                  state_next = WAIT;
                  cnt_next   = n_wait - 8'd2;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_next = IDLE;
            end else if (cnt_reg == 8'd0) begin
               state_next = ACK;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      waitrequest = 1'b0;
      do_write    = 1'b0;
      case (state_reg)
         IDLE:    waitrequest = req;
         WAIT:    waitrequest = 1'b1;
         default: do_write    = write && !fault;
      endcase
   end

   // A master abandoning a stalled transfer is flagged the same way as a decode fault.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_reg  <= LFSR_SEED;
         readdata  <= 32'd0;
         bus_error <= 1'b0;
      end else begin
         if (state_reg == IDLE && req)
            lfsr_reg <= lfsr_step(lfsr_reg);
         if (state_next == ACK && read)
            readdata <= fault ? 32'd0 : mem[idx];
         if ((state_reg == ACK && req && fault) || (state_reg == WAIT && !req))
            bus_error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b])
               mem[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   assign dbg_rdata = mem[dbg_index];

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Bench for avalon_mem_slave: four instances with different wait settings, checked against a transfer-level model.
module tb_avalon_mem_slave;

   localparam int NI = 4;
   localparam int WS [NI] = '{1, 3, 4, 1};
   localparam int RND_K = 3;

   logic          clk = 1'b0;
   logic [31:0]   address = 32'd0;
   logic [31:0]   writedata = 32'd0;
   logic [3:0]    byteenable = 4'd0;
   logic [10:0]   dbg_index = 11'd0;
   logic [NI-1:0] rd = '0;
   logic [NI-1:0] wr = '0;
   logic [NI-1:0] rstn = '0;
   logic [31:0]   rdata [NI];
   logic [31:0]   dbg [NI];
   logic [NI-1:0] wreq;
   logic [NI-1:0] berr;

   always #5 clk = ~clk;

   avalon_mem_slave #(.WAIT_STATES(1)) u0 (
      .clk(clk), .reset(rstn[0]), .address(address), .read(rd[0]), .write(wr[0]),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata[0]),
      .waitrequest(wreq[0]), .bus_error(berr[0]), .dbg_index(dbg_index), .dbg_rdata(dbg[0]));
   avalon_mem_slave #(.WAIT_STATES(3)) u1 (
      .clk(clk), .reset(rstn[1]), .address(address), .read(rd[1]), .write(wr[1]),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata[1]),
      .waitrequest(wreq[1]), .bus_error(berr[1]), .dbg_index(dbg_index), .dbg_rdata(dbg[1]));
   avalon_mem_slave #(.WAIT_STATES(4)) u2 (
      .clk(clk), .reset(rstn[2]), .address(address), .read(rd[2]), .write(wr[2]),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata[2]),
      .waitrequest(wreq[2]), .bus_error(berr[2]), .dbg_index(dbg_index), .dbg_rdata(dbg[2]));
   avalon_mem_slave #(.WAIT_STATES(1), .RANDOM_WAIT(1'b1)) u3 (
      .clk(clk), .reset(rstn[3]), .address(address), .read(rd[3]), .write(wr[3]),
      .byteenable(byteenable), .writedata(writedata), .readdata(rdata[3]),
      .waitrequest(wreq[3]), .bus_error(berr[3]), .dbg_index(dbg_index), .dbg_rdata(dbg[3]));

   int total = 0;
   int bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // ---------------- transfer-level reference model ----------------
   logic [31:0] mm [NI][2048];
   bit          mv [NI][2048];
   bit          busy [NI];
   int          pend [NI];
   int          nw [NI];
   logic [7:0]  lf [NI];
   bit          err_m [NI];
   logic [31:0] rd_m [NI];
   bit          rd_ok [NI];

   function automatic bit mdec(input logic [31:0] a, output int idx);
      longint ua = a;
      idx = 0;
      if (a[1:0] != 2'b00) return 1'b1;
      if (ua < 4096) begin
         idx = int'(ua / 4);
         return 1'b0;
      end
      if (ua >= 64'hBFC0_0000 && ua < 64'hBFC0_1000) begin
         idx = 1024 + int'((ua - 64'hBFC0_0000) / 4);
         return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [7:0] mstep(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         bit req;
         req = rd[k] | wr[k];
         if (!rstn[k]) begin
            busy[k] = 1'b0; err_m[k] = 1'b0; rd_m[k] = 32'd0; rd_ok[k] = 1'b1; lf[k] = 8'hA5;
            check($sformatf("rst_wait%0d", k), 32'(wreq[k]), 32'(req));
            check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
            check($sformatf("rst_berr%0d", k), 32'(berr[k]), 32'd0);
         end else begin
            if (mv[k][dbg_index])
               check($sformatf("dbg%0d", k), dbg[k], mm[k][dbg_index]);
            check($sformatf("berr%0d", k), 32'(berr[k]), 32'(err_m[k]));
            if (!busy[k] && req) begin
               busy[k] = 1'b1;
               pend[k] = 0;
               nw[k]   = WS[k] + ((k == RND_K) ? int'(lf[k][1:0]) : 0);
               lf[k]   = mstep(lf[k]);
            end
            if (busy[k] && req) begin
               check($sformatf("wait%0d", k), 32'(wreq[k]), 32'(pend[k] < nw[k]));
               if (pend[k] == nw[k]) begin
                  int  i;
                  bit  f;
                  f = mdec(address, i) || (rd[k] && wr[k]);
                  if (rd[k]) begin
                     rd_ok[k] = f || mv[k][i];
                     rd_m[k]  = f ? 32'd0 : mm[k][i];
                  end
                  if (rd_ok[k]) check($sformatf("rdata%0d", k), rdata[k], rd_m[k]);
                  if (f) err_m[k] = 1'b1;
                  else if (wr[k]) begin
                     for (int b = 0; b < 4; b++)
                        if (byteenable[b]) mm[k][i][8*b +: 8] = writedata[8*b +: 8];
                     mv[k][i] = mv[k][i] || (byteenable == 4'hF);
                  end
                  busy[k] = 1'b0;
               end else begin
                  pend[k]++;
                  if (rd_ok[k]) check($sformatf("hold%0d", k), rdata[k], rd_m[k]);
               end
            end else begin
               busy[k] = 1'b0;
               check($sformatf("idle_wait%0d", k), 32'(wreq[k]), 32'd0);
               if (rd_ok[k]) check($sformatf("hold%0d", k), rdata[k], rd_m[k]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d,
                       output int stalls, output logic [31:0] q);
      bit done;
      address = a; byteenable = be; writedata = d;
      rd[k] = r; wr[k] = w;
      stalls = 0; q = 32'd0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!wreq[k]) begin
            q = rdata[k];
            done = 1'b1;
         end else begin
            stalls++;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL timeout%0d: stalls %0d, required completion within 40", k, stalls);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      rd = '0; wr = '0;
   endtask

   task automatic peek(input int k, input logic [10:0] i, input logic [31:0] exp, input string nm);
      dbg_index = i;
      @(negedge clk);
      check(nm, dbg[k], exp);
      @(posedge clk); #1;
   endtask

   int          st;
   logic [31:0] q;
   int          st1 [50];
   logic [31:0] raddr [50];
   logic [31:0] pre [16];

   initial begin
      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 2048; i++) begin
            mm[k][i] = 32'd0; mv[k][i] = 1'b0;
         end
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_rdata_lit", rdata[0], 32'd0);
      check("reset_wait_lit", 32'(wreq), 32'd0);
      @(posedge clk); #1;
      rstn = '1;
      @(posedge clk); #1;

      // WAIT_STATES=1: preload, read, byte-enabled write
      xfer(0, 0, 1, 32'h190, 4'hF, 32'd123, st, q);
      xfer(0, 0, 1, 32'h320, 4'hF, 32'h1122_3344, st, q);
      xfer(0, 0, 1, 32'h014, 4'hF, 32'hCAFE_F00D, st, q);
      xfer(0, 0, 1, 32'hFFC, 4'hF, 32'h0BAD_CAFE, st, q);
      idle();
      xfer(0, 1, 0, 32'h190, 4'h0, 32'd0, st, q);
      idle();
      check("rd190_stall", 32'(st), 32'd1);
      check("rd190_data", q, 32'd123);
      check("rd190_berr", 32'(berr[0]), 32'd0);
      xfer(0, 0, 1, 32'h320, 4'b0101, 32'hDEAD_BEEF, st, q);
      idle();
      peek(0, 11'd200, 32'h11AD_33EF, "be_merge_dbg");
      xfer(0, 1, 0, 32'h320, 4'h0, 32'd0, st, q);
      idle();
      check("be_merge_rd", q, 32'h11AD_33EF);
      xfer(0, 1, 0, 32'hFFC, 4'h0, 32'd0, st, q);
      idle();
      check("last_word", q, 32'h0BAD_CAFE);

      // decode faults
      xfer(0, 1, 0, 32'h0000_0002, 4'h0, 32'd0, st, q);
      idle();
      check("misalign_data", q, 32'd0);
      @(negedge clk);
      check("misalign_berr", 32'(berr[0]), 32'd1);
      @(posedge clk); #1;
      xfer(0, 1, 0, 32'h4000_0000, 4'h0, 32'd0, st, q);
      check("miss_data", q, 32'd0);
      xfer(0, 1, 0, 32'h0000_1000, 4'h0, 32'd0, st, q);
      check("edge_data", q, 32'd0);
      xfer(0, 1, 1, 32'h014, 4'hF, 32'hFFFF_FFFF, st, q);
      idle();
      check("rdwr_data", q, 32'd0);
      check("rdwr_stall", 32'(st), 32'd1);
      peek(0, 11'd5, 32'hCAFE_F00D, "rdwr_unchanged");
      check("berr_sticky", 32'(berr[0]), 32'd1);

      // WAIT_STATES=3: instruction window, back-to-back fetches
      xfer(1, 0, 1, 32'hBFC0_0000, 4'hF, 32'h8C01_0064, st, q);
      idle();
      check("ifetch_wr_stall", 32'(st), 32'd3);
      xfer(1, 1, 0, 32'hBFC0_0000, 4'h0, 32'd0, st, q);
      check("ifetch_stall", 32'(st), 32'd3);
      check("ifetch_data", q, 32'h8C01_0064);
      xfer(1, 1, 0, 32'hBFC0_0000, 4'h0, 32'd0, st, q);
      idle();
      check("ifetch_b2b_stall", 32'(st), 32'd3);
      peek(1, 11'd1024, 32'h8C01_0064, "ifetch_dbg");
      xfer(1, 1, 0, 32'hBFC0_1000, 4'h0, 32'd0, st, q);
      check("instr_edge", q, 32'd0);
      xfer(1, 1, 0, 32'hBFBF_FFFC, 4'h0, 32'd0, st, q);
      idle();
      check("instr_below", q, 32'd0);

      // WAIT_STATES=4: reset during the second WAIT cycle of a write
      xfer(2, 0, 1, 32'h040, 4'hF, 32'h55AA_55AA, st, q);
      idle();
      check("ws4_stall", 32'(st), 32'd4);
      address = 32'h040; writedata = 32'h1234_5678; byteenable = 4'hF; wr[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn[2] = 1'b0;
      @(negedge clk);
      check("ws4_rst_rdata", rdata[2], 32'd0);
      check("ws4_rst_berr", 32'(berr[2]), 32'd0);
      @(posedge clk); #1;
      wr[2] = 1'b0;
      peek(2, 11'd16, 32'h55AA_55AA, "ws4_rst_unchanged");
      rstn[2] = 1'b1;
      @(posedge clk); #1;
      xfer(2, 0, 1, 32'h040, 4'hF, 32'h1234_5678, st, q);
      idle();
      check("ws4_retry_stall", 32'(st), 32'd4);
      peek(2, 11'd16, 32'h1234_5678, "ws4_retry_dbg");

      // RANDOM_WAIT=1: preload, then two identical runs of 50 reads after reset
      for (int i = 0; i < 16; i++) begin
         pre[i] = $urandom;
         xfer(RND_K, 0, 1, 32'(i * 4), 4'hF, pre[i], st, q);
      end
      for (int i = 0; i < 50; i++) raddr[i] = 32'($urandom_range(0, 15) * 4);
      idle();
      for (int run = 0; run < 2; run++) begin
         rstn[RND_K] = 1'b0;
         @(posedge clk); #1;
         rstn[RND_K] = 1'b1;
         @(posedge clk); #1;
         for (int i = 0; i < 50; i++) begin
            xfer(RND_K, 1, 0, raddr[i], 4'h0, 32'd0, st, q);
            check("rnd_data", q, pre[raddr[i] >> 2]);
            if (run == 0) begin
               check("rnd_range", 32'(st >= 1 && st <= 4), 32'd1);
               if (i == 0) check("rnd_first_lit", 32'(st), 32'd2);
               if (i == 1) check("rnd_second_lit", 32'(st), 32'd3);
               st1[i] = st;
            end else begin
               check("rnd_repeat", 32'(st), 32'(st1[i]));
            end
         end
         idle();
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
